// File: rtl/pcs_rx_10g_if.sv
// 10GBASE-R receive PCS signal bundle: gearbox-side block input, slip/lock status and MAC-side decode.
interface pcs_rx_10g_if #(
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int KEEP_W = 8
);
  logic              valid_i;
  logic [HEAD_W-1:0] head_i;
  logic [DATA_W-1:0] data_i;
  logic              slip_o;
  logic              block_lock_o;
  logic              valid_o;
  logic              ctrl_v_o;
  logic              idle_v_o;
  logic [1:0]        start_v_o;
  logic              term_v_o;
  logic              err_v_o;
  logic [DATA_W-1:0] data_o;
  logic [KEEP_W-1:0] keep_o;

  modport master (
    output valid_i, head_i, data_i,
    input  slip_o, block_lock_o, valid_o, ctrl_v_o, idle_v_o, start_v_o,
           term_v_o, err_v_o, data_o, keep_o
  );

  modport slave (
    input  valid_i, head_i, data_i,
    output slip_o, block_lock_o, valid_o, ctrl_v_o, idle_v_o, start_v_o,
           term_v_o, err_v_o, data_o, keep_o
  );
endinterface

// File: rtl/pcs_rx_10g.sv
// 10GBASE-R receive PCS lane: sync-header block lock with bit-slip requests, x^58+x^39+1
// self-synchronous descrambler and 64b/66b control block decode, registered with latency 1.
module pcs_rx_10g #(
  parameter int DATA_W      = 64,
  parameter int HEAD_W      = 2,
  parameter int KEEP_W      = 8,
  parameter int SH_GOOD_N   = 64,
  parameter int SH_BAD_N    = 16,
  parameter int SLIP_WAIT_N = 2
) (
  input  logic        clk,
  input  logic        reset,
  pcs_rx_10g_if.slave bus
);
  localparam logic [6:0] LP_GOOD = 7'(SH_GOOD_N);
  localparam logic [4:0] LP_BAD  = 5'(SH_BAD_N);
  localparam logic [6:0] LP_WAIT = 7'(SLIP_WAIT_N);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_SLIP} state_t;

  state_t            r_state;
  logic [6:0]        r_sh_cnt;
  logic [4:0]        r_bad_cnt;
  logic              r_slip;
  logic              r_lock;
  logic [57:0]       r_scr;
  logic              r_valid, r_ctrl, r_idle, r_term, r_err;
  logic [1:0]        r_start;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;

  logic [HEAD_W-1:0] w_head;
  logic              w_good;
  logic [6:0]        w_sh_nxt;
  logic [4:0]        w_bad_nxt;
  logic [DATA_W-1:0] w_desc, w_shift, w_data;
  logic [57:0]       w_scr_nxt;
  logic              w_vld, w_ctrl, w_idle, w_term, w_err, w_is_term;
  logic [1:0]        w_start;
  logic [KEEP_W-1:0] w_keep, w_t_keep;

  assign w_head    = bus.head_i;
  assign w_good    = (w_head == 2'b01) || (w_head == 2'b10);
  assign w_sh_nxt  = r_sh_cnt + 7'd1;
  assign w_bad_nxt = r_bad_cnt + {4'd0, ~w_good};

  // In SLIP, r_sh_cnt counts the blocks skipped while the gearbox realigns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_UNLOCKED;
      r_sh_cnt  <= '0;
      r_bad_cnt <= '0;
      r_slip    <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      r_slip <= 1'b0;
      if (bus.valid_i) begin
        case (r_state)
          ST_UNLOCKED: begin
            if (!w_good) begin
              r_state   <= ST_SLIP;
              r_slip    <= 1'b1;
              r_sh_cnt  <= '0;
              r_bad_cnt <= '0;
            end else if (w_sh_nxt == LP_GOOD) begin
              r_state   <= ST_LOCKED;
              r_lock    <= 1'b1;
              r_sh_cnt  <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_sh_cnt  <= w_sh_nxt;
            end
          end
          ST_LOCKED: begin
            if (w_bad_nxt == LP_BAD) begin
              r_state   <= ST_SLIP;
              r_lock    <= 1'b0;
              r_slip    <= 1'b1;
              r_sh_cnt  <= '0;
              r_bad_cnt <= '0;
            end else if (w_sh_nxt == LP_GOOD) begin
              r_sh_cnt  <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_sh_cnt  <= w_sh_nxt;
              r_bad_cnt <= w_bad_nxt;
            end
          end
          ST_SLIP: begin
            if (w_sh_nxt == LP_WAIT) begin
              r_state  <= ST_UNLOCKED;
              r_sh_cnt <= '0;
            end else begin
              r_sh_cnt <= w_sh_nxt;
            end
          end
          default: r_state <= ST_UNLOCKED;
        endcase
      end
    end
  end

  // Bit-serial descramble; s[0] is the most recently received scrambled bit.
  always_comb begin
    logic [57:0] s;
    s      = r_scr;
    w_desc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_desc[i] = bus.data_i[i] ^ s[38] ^ s[57];
      s         = {s[56:0], bus.data_i[i]};
    end
    w_scr_nxt = s;
  end

  assign w_shift = {8'h00, w_desc[DATA_W-1:8]};
  assign w_vld   = bus.valid_i && (r_state == ST_LOCKED);

  always_comb begin
    w_t_keep  = '0;
    w_is_term = 1'b1;
    case (w_desc[7:0])
      8'h87:   w_t_keep = 8'h00;
      8'h99:   w_t_keep = 8'h01;
      8'hAA:   w_t_keep = 8'h03;
      8'hB4:   w_t_keep = 8'h07;
      8'hCC:   w_t_keep = 8'h0F;
      8'hD2:   w_t_keep = 8'h1F;
      8'hE1:   w_t_keep = 8'h3F;
      8'hFF:   w_t_keep = 8'h7F;
      default: w_is_term = 1'b0;
    endcase
  end

  always_comb begin
    w_ctrl  = 1'b0;
    w_idle  = 1'b0;
    w_start = '0;
    w_term  = 1'b0;
    w_err   = 1'b0;
    w_data  = '0;
    w_keep  = '0;
    if (w_vld) begin
      if (w_head == 2'b10) begin
        w_data = w_desc;
        w_keep = '1;
      end else if (w_head == 2'b01) begin
        w_ctrl = 1'b1;
        if (w_desc[7:0] == 8'h1E) begin
          if (w_desc[DATA_W-1:8] == '0) w_idle = 1'b1;
          else                          w_err  = 1'b1;
        end else if (w_desc[7:0] == 8'h78) begin
          w_start = 2'b01;
          w_data  = {w_desc[DATA_W-1:8], 8'h00};
          w_keep  = 8'hFE;
        end else if (w_desc[7:0] == 8'h33) begin
          w_start              = 2'b10;
          w_data[DATA_W-1:40]  = w_desc[DATA_W-1:40];
          w_keep               = 8'hE0;
        end else if (w_is_term) begin
          w_term = 1'b1;
          w_keep = w_t_keep;
          for (int b = 0; b < KEEP_W; b++)
            w_data[8*b +: 8] = w_t_keep[b] ? w_shift[8*b +: 8] : 8'h00;
        end else begin
          w_err = 1'b1;
        end
      end else begin
        w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scr   <= '0;
      r_valid <= 1'b0;
      r_ctrl  <= 1'b0;
      r_idle  <= 1'b0;
      r_start <= '0;
      r_term  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
    end else begin
      if (bus.valid_i) r_scr <= w_scr_nxt;
      r_valid <= w_vld;
      r_ctrl  <= w_ctrl;
      r_idle  <= w_idle;
      r_start <= w_start;
      r_term  <= w_term;
      r_err   <= w_err;
      r_data  <= w_data;
      r_keep  <= w_keep;
    end
  end

  assign bus.slip_o       = r_slip;
  assign bus.block_lock_o = r_lock;
  assign bus.valid_o      = r_valid;
  assign bus.ctrl_v_o     = r_ctrl;
  assign bus.idle_v_o     = r_idle;
  assign bus.start_v_o    = r_start;
  assign bus.term_v_o     = r_term;
  assign bus.err_v_o      = r_err;
  assign bus.data_o       = r_data;
  assign bus.keep_o       = r_keep;
endmodule

// File: tb/tb_pcs_rx_10g.sv
// Randomized scoreboard bench for pcs_rx_10g: plaintext blocks are scrambled by a stream model,
// expected decodes are queued at issue time and popped by an independent output monitor.
module tb_pcs_rx_10g;
  localparam int SH_GOOD_N   = 64;
  localparam int SH_BAD_N    = 16;
  localparam int SLIP_WAIT_N = 2;
  localparam bit [7:0] TCODES [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  localparam bit [7:0] OTHERS [6] = '{8'h2D, 8'h4B, 8'h55, 8'h66, 8'h00, 8'h1F};

  typedef struct packed {
    bit        ctrl;
    bit        idle;
    bit [1:0]  start;
    bit        term;
    bit        err;
    bit [63:0] data;
    bit [7:0]  keep;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pcs_rx_10g_if bus();
  pcs_rx_10g dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   hist[$];

  bit m_lock, m_slip;
  int m_run, m_win, m_bad, m_skip;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scrambled stream: tx[n] = p[n] ^ tx[n-39] ^ tx[n-58]; hist holds the last 58 tx bits, oldest first.
  function automatic bit [63:0] scramble(input bit [63:0] p);
    bit [63:0] s;
    for (int i = 0; i < 64; i++) begin
      s[i] = p[i] ^ hist[19] ^ hist[0];
      hist.push_back(s[i]);
      void'(hist.pop_front());
    end
    return s;
  endfunction

  function automatic int term_pos(input bit [7:0] t);
    for (int i = 0; i < 8; i++) if (TCODES[i] == t) return i;
    return -1;
  endfunction

  function automatic exp_t decode_ref(input bit [1:0] h, input bit [63:0] p);
    exp_t      e;
    int        k;
    bit [63:0] mask;
    e = '0;
    k = term_pos(p[7:0]);
    if (h == 2'b10) begin
      e.data = p;
      e.keep = 8'hFF;
    end else if (h == 2'b01) begin
      e.ctrl = 1'b1;
      if (p[7:0] == 8'h1E) begin
        if (p[63:8] == 56'd0) e.idle = 1'b1;
        else                  e.err  = 1'b1;
      end else if (p[7:0] == 8'h78) begin
        e.start = 2'b01;
        e.data  = p & ~64'hFF;
        e.keep  = 8'hFE;
      end else if (p[7:0] == 8'h33) begin
        e.start = 2'b10;
        e.data  = p & 64'hFFFFFF00_00000000;
        e.keep  = 8'hE0;
      end else if (k >= 0) begin
        mask   = (64'd1 << (8 * k)) - 64'd1;
        e.term = 1'b1;
        e.data = (p >> 8) & mask;
        e.keep = 8'((1 << k) - 1);
      end else begin
        e.err = 1'b1;
      end
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_block(input bit good);
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_lock) begin
      if (!good) begin
        m_slip = 1'b1;
        m_skip = SLIP_WAIT_N;
        m_run  = 0;
      end else begin
        m_run++;
        if (m_run == SH_GOOD_N) begin
          m_lock = 1'b1;
          m_run  = 0;
          m_win  = 0;
          m_bad  = 0;
        end
      end
    end else begin
      m_win++;
      if (!good) m_bad++;
      if (m_bad == SH_BAD_N) begin
        m_lock = 1'b0;
        m_slip = 1'b1;
        m_skip = SLIP_WAIT_N;
        m_win  = 0;
        m_bad  = 0;
      end else if (m_win == SH_GOOD_N) begin
        m_win = 0;
        m_bad = 0;
      end
    end
  endfunction

  task automatic chk_lock();
    check("block_lock", bus.block_lock_o, m_lock);
    check("slip", bus.slip_o, m_slip);
  endtask

  task automatic gen(input bit allow_bad, output bit [1:0] h, output bit [63:0] p);
    int r;
    p = {$urandom, $urandom};
    r = $urandom_range(0, 99);
    if (allow_bad && r < 3) h = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    else if (r < 50) h = 2'b10;
    else begin
      h = 2'b01;
      case ($urandom_range(0, 5))
        0:       p = 64'h1E;
        1:       p[7:0] = 8'h1E;
        2:       p[7:0] = 8'h78;
        3:       p[7:0] = 8'h33;
        4:       p[7:0] = TCODES[$urandom_range(0, 7)];
        default: p[7:0] = OTHERS[$urandom_range(0, 5)];
      endcase
    end
  endtask

  task automatic send(input bit v, input bit [1:0] h, input bit [63:0] p);
    @(negedge clk);
    chk_lock();
    bus.valid_i = v;
    bus.head_i  = h;
    bus.data_i  = v ? scramble(p) : {$urandom, $urandom};
    @(posedge clk);
    m_slip = 1'b0;
    if (v) begin
      if (m_lock) sb.push_back(decode_ref(h, p));
      model_block(h == 2'b01 || h == 2'b10);
    end
  endtask

  task automatic send_rand(input int n, input bit allow_bad);
    bit [1:0]  h;
    bit [63:0] p;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) send(1'b0, 2'b00, 64'd0);
      gen(allow_bad, h, p);
      send(1'b1, h, p);
    end
  endtask

  task automatic window(input int nbad);
    bit        badpos [64];
    int        c;
    int        j;
    bit [1:0]  h;
    bit [63:0] p;
    badpos = '{default: 1'b0};
    c = 0;
    if (nbad == SH_BAD_N) begin
      badpos[63] = 1'b1;
      c = 1;
    end
    while (c < nbad) begin
      j = $urandom_range(0, 62);
      if (!badpos[j]) begin
        badpos[j] = 1'b1;
        c++;
      end
    end
    for (int i = 0; i < 64; i++) begin
      gen(1'b0, h, p);
      send(1'b1, badpos[i] ? 2'b00 : h, p);
    end
  endtask

  task automatic chk_quiet(input string name);
    check({name, "_lock"}, {bus.block_lock_o, bus.slip_o, bus.valid_o}, 3'b000);
    check({name, "_flags"}, {bus.ctrl_v_o, bus.idle_v_o, bus.start_v_o, bus.term_v_o,
                             bus.err_v_o, bus.keep_o}, 14'd0);
    check({name, "_data"}, bus.data_o, 64'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.valid_i = 1'b0;
    sb.delete();
    hist.delete();
    repeat (58) hist.push_back(1'b0);
    m_lock = 1'b0; m_slip = 1'b0;
    m_run = 0; m_win = 0; m_bad = 0; m_skip = 0;
    #1;
    chk_quiet("reset_now");
    repeat (2) @(negedge clk);
    chk_quiet("reset_held");
    reset = 1'b0;
  endtask

  // Monitor: every expected block must appear exactly one cycle after issue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("valid_o", bus.valid_o, 64'(sb.size() != 0));
        if (bus.valid_o === 1'b1 && sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("ctrl_v", bus.ctrl_v_o, mon_e.ctrl);
          check("idle_v", bus.idle_v_o, mon_e.idle);
          check("start_v", bus.start_v_o, mon_e.start);
          check("term_v", bus.term_v_o, mon_e.term);
          check("err_v", bus.err_v_o, mon_e.err);
          check("data", bus.data_o, mon_e.data);
          check("keep", bus.keep_o, mon_e.keep);
        end else if (bus.valid_o === 1'b0) begin
          check("idle_out", {bus.ctrl_v_o, bus.idle_v_o, bus.start_v_o, bus.term_v_o,
                             bus.err_v_o, bus.keep_o}, 14'd0);
          check("idle_data", bus.data_o, 64'd0);
        end
      end
    end
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.head_i  = 2'b00;
    bus.data_i  = 64'd0;
    #1;
    do_reset();

    // 63 good headers leave lock low, the 64th raises it a cycle later
    send_rand(63, 1'b0);
    send(1'b0, 2'b00, 64'd0);
    send_rand(1, 1'b0);
    send(1'b0, 2'b00, 64'd0);

    // decode while locked: idle, start, data, terminate at lane 3, unknown type
    send(1'b1, 2'b01, 64'h1E);
    send(1'b1, 2'b01, {$urandom, $urandom_range(0, 16777215), 8'h78});
    send(1'b1, 2'b10, {$urandom, $urandom});
    send(1'b1, 2'b01, 64'h00000000_CCBBAAB4);
    send(1'b1, 2'b01, 64'h00000000_0000002D);

    // bad header on block 10 while hunting, two ignored blocks, then a fresh 64 needed
    do_reset();
    send_rand(9, 1'b0);
    send(1'b1, 2'b11, {$urandom, $urandom});
    send(1'b0, 2'b00, 64'd0);
    send(1'b1, 2'b00, {$urandom, $urandom});
    send(1'b1, 2'b11, {$urandom, $urandom});
    send_rand(63, 1'b0);
    send(1'b0, 2'b00, 64'd0);
    send_rand(1, 1'b0);
    send(1'b0, 2'b00, 64'd0);

    // windowed bad-header monitor: 15 bad holds, 16 bad (last on block 64) drops
    do_reset();
    send_rand(64, 1'b0);
    window(15);
    window(15);
    window(16);
    send(1'b0, 2'b00, 64'd0);
    send_rand(2 + 64, 1'b0);
    send(1'b0, 2'b00, 64'd0);

    send_rand(400, 1'b1);

    // asynchronous reset in the middle of a frame
    send_rand(70, 1'b0);
    send(1'b1, 2'b01, {$urandom, $urandom_range(0, 16777215), 8'h78});
    send(1'b1, 2'b01, {$urandom, $urandom_range(0, 16777215), 8'h2D});
    send(1'b1, 2'b10, {$urandom, $urandom});
    #2;
    do_reset();
    send_rand(5, 1'b0);
    @(negedge clk);
    chk_lock();
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
